// File: rtl/mul32_pkg.sv
// Shared constants, stage-1 record and operand helpers for the mul32 fixed-point multiplier.
package mul32_pkg;

    localparam int WORD_W = 32;
    localparam int PROD_W = 64;
    localparam int HALF_W = 16;
    localparam int STAGES = 2;

    localparam logic [WORD_W-1:0] SAT_POS = 32'h7FFFFFFF;
    localparam logic [WORD_W-1:0] SAT_NEG = 32'h80000000;

    // Partial products are indexed {a_half, b_half}: [3]=hh, [2]=hl, [1]=lh, [0]=ll.
    typedef struct packed {
        logic                   neg;
        logic [3:0][WORD_W-1:0] pp;
    } stage1_t;

    // Unsigned magnitude; 0x80000000 maps to 2^31, which still fits in WORD_W bits.
    function automatic logic [WORD_W-1:0] magnitude(input logic [WORD_W-1:0] x);
        return x[WORD_W-1] ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/mul16u.sv
// Combinational 16x16 -> 32 unsigned multiplier, one per partial product.
module mul16u
    import mul32_pkg::*;
(
    input  logic [HALF_W-1:0] a,
    input  logic [HALF_W-1:0] b,
    output logic [WORD_W-1:0] p
);

    assign p = WORD_W'(a) * WORD_W'(b);

endmodule

// File: rtl/mul32.sv
// Two-stage signed fixed-point multiplier: Q(31-FRAC_BITS).FRAC_BITS operands and result.
// Define MUL32_SAT_EN to clamp overflowing results instead of wrapping them.
module mul32
    import mul32_pkg::*;
#(
    parameter int FRAC_BITS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] input1,
    input  logic [WORD_W-1:0] input2,
    output logic              out_valid,
    output logic [WORD_W-1:0] o,
    output logic              ovf
);

    logic [STAGES:1]          vld_pipe;
    logic [1:0][HALF_W-1:0]   a_half;
    logic [1:0][HALF_W-1:0]   b_half;
    logic [3:0][WORD_W-1:0]   pp_c;
    stage1_t                  s1;

    logic [WORD_W:0]          mid;
    logic [PROD_W-1:0]        mag;
    logic [PROD_W-1:0]        prod;
    logic signed [PROD_W-1:0] prod_hi;
    logic [WORD_W-1:0]        o_wrap;
    logic [WORD_W-1:0]        o_next;
    logic                     ovf_next;

    assign a_half = magnitude(input1);
    assign b_half = magnitude(input2);

    for (genvar i = 0; i < 4; i++) begin : g_pp
        mul16u u_mul (
            .a (a_half[i / 2]),
            .b (b_half[i % 2]),
            .p (pp_c[i])
        );
    end

    // Operands are only captured on in_valid so idle-cycle garbage never reaches stage 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe[1] <= 1'b0;
            s1          <= '0;
        end else begin
            vld_pipe[1] <= in_valid;
            if (in_valid) begin
                s1.neg <= input1[WORD_W-1] ^ input2[WORD_W-1];
                s1.pp  <= pp_c;
            end
        end
    end

    // |P| <= 2^62, so bit 63 of the signed product is always the true sign.
    always_comb begin
        mid      = (WORD_W + 1)'(s1.pp[2]) + (WORD_W + 1)'(s1.pp[1]);
        mag      = {s1.pp[3], 32'b0} + (PROD_W'(mid) << HALF_W) + PROD_W'(s1.pp[0]);
        prod     = s1.neg ? -mag : mag;
        o_wrap   = WORD_W'(prod >> FRAC_BITS);
        prod_hi  = $signed(prod) >>> (FRAC_BITS + WORD_W - 1);
        ovf_next = !((prod_hi == '0) || (&prod_hi));
`ifdef MUL32_SAT_EN
        o_next   = ovf_next ? (prod[PROD_W-1] ? SAT_NEG : SAT_POS) : o_wrap;
`else
        o_next   = o_wrap;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe[2] <= 1'b0;
            o           <= '0;
            ovf         <= 1'b0;
        end else begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) begin
                o   <= o_next;
                ovf <= ovf_next;
            end
        end
    end

    assign out_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_mul32.sv
// Self-checking bench for mul32: directed vector table, reset-abort sequence, random stream vs 64-bit model.
module tb_mul32;

    localparam int FRAC = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] input1 = '0;
    logic [31:0] input2 = '0;
    logic        out_valid;
    logic [31:0] o;
    logic        ovf;

    int vecs = 0;
    int miss = 0;

    mul32 #(.FRAC_BITS(FRAC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .input1    (input1),
        .input2    (input2),
        .out_valid (out_valid),
        .o         (o),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] o;
        logic        ovf;
        string       name;
    } vec_t;

    typedef struct {
        logic        v;
        logic [31:0] o;
        logic        ovf;
    } exp_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: exact signed product, floor-divide by 2^FRAC, range check on what was dropped.
    function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic r_ovf);
        longint p;
        longint hi;
        p     = longint'($signed(a)) * longint'($signed(b));
        hi    = p >>> (FRAC + 31);
        r_ovf = !(hi == 0 || hi == -1);
        r     = 32'(p >>> FRAC);
`ifdef MUL32_SAT_EN
        if (r_ovf) r = (p < 0) ? 32'h80000000 : 32'h7FFFFFFF;
`endif
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [6] = '{32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF,
                                     32'h00000000, 32'h00010000, 32'hFFFF0000};
        logic [31:0] r;
        case ($urandom_range(0, 3))
            0:       r = corners[$urandom_range(0, 5)];
            1:       r = 32'($signed($urandom_range(0, 32'h000FFFFF)) - 32'sh00080000);
            default: r = $urandom;
        endcase
        return r;
    endfunction

    // Isolated pair: check exact latency, result, then that out_valid drops and o/ovf hold.
    task automatic apply_one(input vec_t v);
        @(posedge clk); #1;
        input1 = v.a; input2 = v.b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; input1 = $urandom; input2 = $urandom;
        check($sformatf("%s early", v.name), out_valid, 0);
        @(posedge clk); #1;
        check($sformatf("%s valid", v.name), out_valid, 1);
        check($sformatf("%s o", v.name), o, v.o);
        check($sformatf("%s ovf", v.name), ovf, v.ovf);
        @(posedge clk); #1;
        check($sformatf("%s drop", v.name), out_valid, 0);
        check($sformatf("%s hold", v.name), o, v.o);
    endtask

    vec_t        tbl [11];
    exp_t        hist [$];
    exp_t        e;
    vec_t        seq [5];
    logic [31:0] last_o;
    logic        last_ovf;
    logic [31:0] ra, rb, ro;
    logic        rovf;
    int          sent;
    int          idle_tail;

    initial begin
        logic [31:0] sat_p_or_0;
        logic [31:0] sat_p_or_ffff;
        logic [31:0] sat_p_or_8000;
`ifdef MUL32_SAT_EN
        sat_p_or_0    = 32'h7FFFFFFF;
        sat_p_or_ffff = 32'h7FFFFFFF;
        sat_p_or_8000 = 32'h7FFFFFFF;
`else
        sat_p_or_0    = 32'h00000000;
        sat_p_or_ffff = 32'hFFFF0000;
        sat_p_or_8000 = 32'h80000000;
`endif
        tbl[0]  = '{32'h00010000, 32'h00010000, 32'h00010000,  1'b0, "one_x_one"};
        tbl[1]  = '{32'hFFFF0000, 32'h00028000, 32'hFFFD8000,  1'b0, "neg1_x_2p5"};
        tbl[2]  = '{32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF,  1'b0, "floor_lsb"};
        tbl[3]  = '{32'h80000000, 32'h80000000, sat_p_or_0,    1'b1, "min_x_min"};
        tbl[4]  = '{32'h00008000, 32'h00008000, 32'h00004000,  1'b0, "half_x_half"};
        tbl[5]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000,  1'b0, "neglsb_sq"};
        tbl[6]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, sat_p_or_ffff, 1'b1, "max_x_max"};
        tbl[7]  = '{32'h40000000, 32'h00020000, sat_p_or_8000, 1'b1, "pos_edge_ovf"};
        tbl[8]  = '{32'hC0000000, 32'h00020000, 32'h80000000,  1'b0, "neg_edge_fit"};
        tbl[9]  = '{32'h80000000, 32'h00010000, 32'h80000000,  1'b0, "min_x_one"};
        tbl[10] = '{32'h80000000, 32'hFFFF0000, sat_p_or_8000, 1'b1, "min_x_negone"};

        // Reset state
        #2 rst = 1'b0;
        #1;
        check("reset out_valid", out_valid, 0);
        check("reset o", o, 0);
        check("reset ovf", ovf, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        foreach (tbl[i]) apply_one(tbl[i]);

        // Four back-to-back pairs, reset after the second output, then a pair at release.
        seq[0] = '{32'h00030000, 32'h00020000, 32'h00060000, 1'b0, "b2b_0"};
        seq[1] = '{32'hFFFE0000, 32'h00018000, 32'hFFFD0000, 1'b0, "b2b_1"};
        seq[2] = '{32'h00050000, 32'h00050000, 32'h00190000, 1'b0, "b2b_2"};
        seq[3] = '{32'h00070000, 32'h00010000, 32'h00070000, 1'b0, "b2b_3"};
        seq[4] = '{32'h00024000, 32'h00020000, 32'h00048000, 1'b0, "post_rst"};

        @(posedge clk); #1;
        input1 = seq[0].a; input2 = seq[0].b; in_valid = 1'b1;
        @(posedge clk); #1;
        input1 = seq[1].a; input2 = seq[1].b;
        check("b2b early", out_valid, 0);
        @(posedge clk); #1;
        check("b2b_0 valid", out_valid, 1);
        check("b2b_0 o", o, seq[0].o);
        input1 = seq[2].a; input2 = seq[2].b;
        @(posedge clk); #1;
        check("b2b_1 valid", out_valid, 1);
        check("b2b_1 o", o, seq[1].o);
        input1 = seq[3].a; input2 = seq[3].b;
        #2 rst = 1'b0;
        #1;
        check("async clr out_valid", out_valid, 0);
        check("async clr o", o, 0);
        check("async clr ovf", ovf, 0);
        @(posedge clk); #1;
        check("rst held out_valid", out_valid, 0);
        #2;
        rst = 1'b1;
        input1 = seq[4].a; input2 = seq[4].b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("no stale pulse", out_valid, 0);
        @(posedge clk); #1;
        check("post_rst valid", out_valid, 1);
        check("post_rst o", o, seq[4].o);
        @(posedge clk); #1;
        check("post_rst drop", out_valid, 0);
        @(posedge clk); #1;
        check("post_rst quiet", out_valid, 0);
        last_o   = seq[4].o;
        last_ovf = 1'b0;

        // Random stream: entry driven after edge k is due after edge k+2.
        sent      = 0;
        idle_tail = 0;
        while (idle_tail < 3) begin
            @(posedge clk); #1;
            if (hist.size() >= 2) begin
                e = hist.pop_front();
                check("rnd out_valid", out_valid, e.v);
                if (e.v) begin
                    check("rnd o", o, e.o);
                    check("rnd ovf", ovf, e.ovf);
                    last_o   = e.o;
                    last_ovf = e.ovf;
                end else begin
                    check("rnd hold o", o, last_o);
                    check("rnd hold ovf", ovf, last_ovf);
                end
            end
            if (sent < 1000 && $urandom_range(0, 4) != 0) begin
                ra = pick_operand();
                rb = pick_operand();
                ref_mul(ra, rb, ro, rovf);
                input1 = ra; input2 = rb; in_valid = 1'b1;
                hist.push_back('{1'b1, ro, rovf});
                sent++;
            end else begin
                input1 = $urandom; input2 = $urandom; in_valid = 1'b0;
                hist.push_back('{1'b0, 32'h0, 1'b0});
                if (sent >= 1000) idle_tail++;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
